// File: rtl/latency_credit_buffer.sv
// latency_credit_buffer: tail buffer for a fixed-latency, non-stallable delay pipeline.
// Credits gate the pipeline head so the tail FIFO can always absorb what emerges LATENCY
// cycles later; the FIFO then feeds a valid/ready consumer.
// Optional macro LCB_OVERFLOW_CHECK_EN: enables the sticky overflow_err check (tied 0 otherwise).
module latency_credit_buffer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    issue_valid,
   output logic                    issue_ready,
   input  logic                    pipe_valid,
   input  logic [DATA_WIDTH-1:0]   pipe_data,
   output logic                    down_valid,
   output logic [DATA_WIDTH-1:0]   down_data,
   input  logic                    down_ready,
   output logic [$clog2(DEPTH):0]  credits,
   output logic                    overflow_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] DepthP = PW'(DEPTH);

   logic [PW-1:0]         credits_q, credits_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  init_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] count;
   logic          full;
   logic          empty;
   logic          issue_acc;
   logic          pop;
   logic          wr_mem;
   logic          wr_adv;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;

   // Occupancy from pointer difference; the extra MSB separates full from empty.
   assign count  = wr_ptr_q - rd_ptr_q;
   assign full   = (count == DepthP);
   assign empty  = (count == '0);
   assign wr_idx = wr_ptr_q[AW-1:0];
   assign rd_idx = rd_ptr_q[AW-1:0];

   // init_q holds off issue_ready until the first clock after reset release.
   assign issue_ready = init_q && (credits_q != '0);
   assign issue_acc   = issue_valid && issue_ready;
   assign down_valid  = !empty;
   assign down_data   = mem_q[rd_idx];
   assign pop         = down_valid && down_ready;
   assign credits     = credits_q;

   // A write on a full FIFO only advances when a pop frees the head slot the same cycle.
   assign wr_adv = pipe_valid && (!full || pop);

`ifdef LCB_OVERFLOW_CHECK_EN
   logic ovf_q;
   logic ovf_set;

   // Dropped tail write, or a pop that would return a credit the counter never issued.
   assign ovf_set      = (pipe_valid && full && !pop) || (pop && (credits_q == DepthP));
   assign wr_mem       = wr_adv;
   assign overflow_err = ovf_q;

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovf_q <= 1'b0;
      end else if (ovf_set) begin
         ovf_q <= 1'b1;
      end
   end
`else
   // Unchecked: a full-FIFO write without a pop lands on the head slot.
   assign wr_mem       = pipe_valid;
   assign overflow_err = 1'b0;
`endif

   // Next-state for credit counter and FIFO pointers.
   always_comb begin
      credits_d = credits_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (issue_acc && !pop) begin
         credits_d = credits_q - PW'(1);
      end else if (pop && !issue_acc && (credits_q != DepthP)) begin
         credits_d = credits_q + PW'(1);
      end
      if (wr_adv) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         credits_q <= DepthP;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         init_q    <= 1'b0;
      end else begin
         credits_q <= credits_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         init_q    <= 1'b1;
      end
   end

   // FIFO storage; reset so down_data reads zero out of reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_mem) begin
         mem_q[wr_idx] <= pipe_data;
      end
   end

   // Structural sanity checks; LATENCY is carried for documentation and checking only.
   a_params: assert property (@(posedge clk)
      (LATENCY >= 1) && (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
   a_credits_range: assert property (@(posedge clk) disable iff (!resetn)
      credits_q <= DepthP);
   a_count_range: assert property (@(posedge clk) disable iff (!resetn)
      count <= DepthP);

endmodule

// File: tb/tb_latency_credit_buffer.sv
// Self-checking bench for latency_credit_buffer: a behavioural delay-pipe plus
// queue/credit model drives and predicts the DUT.
module tb_latency_credit_buffer;

   localparam int DW  = 32;
   localparam int LAT = 4;
   localparam int DEP = 8;

   logic          clk;
   logic          resetn;
   logic          issue_valid;
   logic          issue_ready;
   logic          pipe_valid;
   logic [DW-1:0] pipe_data;
   logic          down_valid;
   logic [DW-1:0] down_data;
   logic          down_ready;
   logic [3:0]    credits;
   logic          overflow_err;

   latency_credit_buffer #(
      .DATA_WIDTH (DW),
      .LATENCY    (LAT),
      .DEPTH      (DEP)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .pipe_valid   (pipe_valid),
      .pipe_data    (pipe_data),
      .down_valid   (down_valid),
      .down_data    (down_data),
      .down_ready   (down_ready),
      .credits      (credits),
      .overflow_err (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   int            m_credits;
   logic [DW-1:0] m_q[$];
   bit            m_pv[LAT];
   logic [DW-1:0] m_pd[LAT];
   bit            m_init;
   bit            m_ovf;
   logic [DW-1:0] issued[$];
   bit            force_pv;
   logic [DW-1:0] force_pd;
   int            checks;
   int            errors;

   task automatic model_clear();
      m_credits = DEP;
      m_q.delete();
      issued.delete();
      for (int i = 0; i < LAT; i++) begin
         m_pv[i] = 1'b0;
         m_pd[i] = '0;
      end
      m_init   = 1'b0;
      m_ovf    = 1'b0;
      force_pv = 1'b0;
      force_pd = '0;
   endtask

   // One clock: drive inputs, take the edge, advance the model, return at negedge.
   task automatic tick(input bit iv, input bit dr);
      bit acc;
      bit pop;
      bit wr;
      bit room;
      issue_valid = iv;
      down_ready  = dr;
      pipe_valid  = m_pv[LAT-1] | force_pv;
      pipe_data   = force_pv ? force_pd : m_pd[LAT-1];
      acc  = iv && m_init && (m_credits != 0);
      pop  = dr && (m_q.size() != 0);
      wr   = pipe_valid;
      room = (m_q.size() < DEP) || pop;
      @(posedge clk);
`ifdef LCB_OVERFLOW_CHECK_EN
      if ((wr && !room) || (pop && m_credits == DEP)) m_ovf = 1'b1;
`endif
      if (pop) void'(m_q.pop_front());
      if (wr && room) m_q.push_back(pipe_data);
      if (acc && !pop) m_credits--;
      else if (pop && !acc && m_credits < DEP) m_credits++;
      for (int i = LAT - 1; i > 0; i--) begin
         m_pv[i] = m_pv[i-1];
         m_pd[i] = m_pd[i-1];
      end
      m_pv[0] = acc;
      m_pd[0] = $urandom;
      if (acc) issued.push_back(m_pd[0]);
      m_init = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      resetn      = 1'b0;
      issue_valid = 1'b0;
      down_ready  = 1'b0;
      pipe_valid  = 1'b0;
      pipe_data   = '0;
      model_clear();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      model_clear();
      issue_valid = 1'b0; down_ready = 1'b0; pipe_valid = 1'b0; pipe_data = '0;
      repeat (2) @(negedge clk);
      checks++; if (credits !== 4'd8) begin errors++;
         $display("FAIL reset_credits got %0d want 8", credits); end
      checks++; if (down_valid !== 1'b0) begin errors++;
         $display("FAIL reset_down_valid got %b want 0", down_valid); end
      checks++; if (down_data !== '0) begin errors++;
         $display("FAIL reset_down_data got %h want 0", down_data); end
      checks++; if (overflow_err !== 1'b0) begin errors++;
         $display("FAIL reset_overflow got %b want 0", overflow_err); end
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0);
         checks++; if (issue_ready !== 1'b1) begin errors++;
            $display("FAIL idle_issue_ready got %b want 1", issue_ready); end
         checks++; if (credits !== 4'd8 || down_valid !== 1'b0 || overflow_err !== 1'b0) begin
            errors++; $display("FAIL idle_state got cr=%0d dv=%b ov=%b want 8/0/0",
                               credits, down_valid, overflow_err); end
      end
   endtask

   task automatic test_latency();
      int n;
      do_reset();
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      n = 0;
      while (down_valid !== 1'b1 && n < 20) begin
         tick(1'b0, 1'b0);
         n++;
      end
      // Issue edge plus LAT more edges: LATENCY+1 cycles issue-to-down_valid.
      checks++; if (n !== LAT) begin errors++;
         $display("FAIL issue_to_valid_latency got %0d want %0d", n + 1, LAT + 1); end
      checks++; if (down_data !== issued[0]) begin errors++;
         $display("FAIL latency_data got %h want %h", down_data, issued[0]); end
   endtask

   task automatic fill_fifo();
      do_reset();
      tick(1'b0, 1'b0);
      for (int i = 0; i < DEP; i++) begin
         tick(1'b1, 1'b0);
         checks++; if (credits !== 4'(DEP - i - 1)) begin errors++;
            $display("FAIL fill_credits[%0d] got %0d want %0d", i, credits, DEP - i - 1); end
      end
      repeat (LAT) tick(1'b0, 1'b0);
   endtask

   task automatic test_fill_drain();
      fill_fifo();
      tick(1'b1, 1'b0);
      checks++; if (credits !== 4'd0 || issue_ready !== 1'b0) begin errors++;
         $display("FAIL full_credits got cr=%0d ir=%b want 0/0", credits, issue_ready); end
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 1'b0);
         checks++; if (down_valid !== 1'b1 || down_data !== issued[0]) begin errors++;
            $display("FAIL hold_head got dv=%b %h want 1 %h", down_valid, down_data, issued[0]); end
      end
      for (int i = 0; i < DEP; i++) begin
         checks++; if (down_valid !== 1'b1 || down_data !== issued[i]) begin errors++;
            $display("FAIL drain_order[%0d] got dv=%b %h want 1 %h",
                     i, down_valid, down_data, issued[i]); end
         tick(1'b0, 1'b1);
      end
      checks++; if (credits !== 4'd8 || down_valid !== 1'b0) begin errors++;
         $display("FAIL drained got cr=%0d dv=%b want 8/0", credits, down_valid); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] prev;
      do_reset();
      tick(1'b0, 1'b0);
      prev = '0;
      for (int i = 0; i < 40; i++) begin
         tick(1'b1, 1'b1);
         if (i >= LAT + 4) begin
            checks++; if (issue_ready !== 1'b1 || down_valid !== 1'b1) begin errors++;
               $display("FAIL stream_stall[%0d] got ir=%b dv=%b want 1/1",
                        i, issue_ready, down_valid); end
            checks++; if (credits !== 4'(m_credits) || credits !== prev) begin errors++;
               $display("FAIL stream_credits[%0d] got %0d want %0d steady",
                        i, credits, m_credits); end
            checks++; if (down_data !== m_q[0]) begin errors++;
               $display("FAIL stream_data[%0d] got %h want %h", i, down_data, m_q[0]); end
         end
         prev = credits;
      end
   endtask

   task automatic test_full_wrap();
      fill_fifo();
      for (int j = 0; j < 4; j++) begin
         force_pv = 1'b1;
         force_pd = $urandom;
         tick(1'b0, 1'b1);
         checks++; if (down_valid !== 1'b1 || down_data !== m_q[0] || overflow_err !== 1'b0)
         begin errors++; $display("FAIL wrap_write[%0d] got dv=%b %h ov=%b want 1 %h 0",
                                  j, down_valid, down_data, overflow_err, m_q[0]); end
      end
      force_pv = 1'b0;
      // Count held at DEPTH: exactly DEPTH more pops before the FIFO empties.
      for (int i = 0; i < DEP; i++) begin
         checks++; if (down_valid !== 1'b1 || down_data !== m_q[0]) begin errors++;
            $display("FAIL wrap_order[%0d] got dv=%b %h want 1 %h",
                     i, down_valid, down_data, m_q[0]); end
         tick(1'b0, 1'b1);
      end
      checks++; if (down_valid !== 1'b0 || overflow_err !== m_ovf) begin errors++;
         $display("FAIL wrap_end got dv=%b ov=%b want 0 %b", down_valid, overflow_err, m_ovf); end
   endtask

`ifdef LCB_OVERFLOW_CHECK_EN
   task automatic test_overflow();
      fill_fifo();
      force_pv = 1'b1;
      force_pd = $urandom;
      tick(1'b0, 1'b0);
      force_pv = 1'b0;
      checks++; if (overflow_err !== 1'b1) begin errors++;
         $display("FAIL overflow_set got %b want 1", overflow_err); end
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, i[0]);
         checks++; if (overflow_err !== 1'b1 || down_data !== m_q[0]) begin errors++;
            $display("FAIL overflow_sticky[%0d] got ov=%b %h want 1 %h",
                     i, overflow_err, down_data, m_q[0]); end
      end
      resetn = 1'b0;
      #1;
      checks++; if (overflow_err !== 1'b0) begin errors++;
         $display("FAIL overflow_clear got %b want 0", overflow_err); end
      @(negedge clk);
      resetn = 1'b1;
   endtask
`endif

   task automatic test_random();
      do_reset();
      tick(1'b0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         tick(($urandom % 4) != 0, ($urandom % 2) != 0);
         checks++; if (issue_ready !== (m_credits != 0) || credits !== 4'(m_credits)) begin
            errors++; $display("FAIL rand_credits[%0d] got ir=%b cr=%0d want %0d",
                               i, issue_ready, credits, m_credits); end
         checks++; if (down_valid !== (m_q.size() != 0) || overflow_err !== m_ovf) begin
            errors++; $display("FAIL rand_valid[%0d] got dv=%b ov=%b want cnt %0d",
                               i, down_valid, overflow_err, m_q.size()); end
         if (m_q.size() != 0) begin
            checks++; if (down_data !== m_q[0]) begin errors++;
               $display("FAIL rand_data[%0d] got %h want %h", i, down_data, m_q[0]); end
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      tick(1'b0, 1'b0);
      repeat (5) tick(1'b1, 1'b0);
      repeat (2) tick(1'b0, 1'b0);
      // Three words buffered and two still in the delay pipe.
      checks++; if (down_valid !== 1'b1 || credits !== 4'(DEP - 3 - 2)) begin errors++;
         $display("FAIL pre_reset got dv=%b cr=%0d want 1 %0d", down_valid, credits, DEP - 5); end
      #2 resetn = 1'b0;
      #1;
      checks++; if (down_valid !== 1'b0 || credits !== 4'd8) begin errors++;
         $display("FAIL async_reset got dv=%b cr=%0d want 0 8", down_valid, credits); end
      model_clear();
      issue_valid = 1'b0; down_ready = 1'b0; pipe_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < LAT + 2; i++) begin
         tick(1'b0, 1'b0);
         checks++; if (down_valid !== 1'b0 || credits !== 4'd8 || issue_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset[%0d] got dv=%b cr=%0d ir=%b want 0 8 1",
                               i, down_valid, credits, issue_ready); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_latency();
      test_fill_drain();
      test_back_to_back();
      test_full_wrap();
`ifdef LCB_OVERFLOW_CHECK_EN
      test_overflow();
`endif
      test_random();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
